// File: rtl/mmu_mem_arbiter.sv
// mmu_mem_arbiter: round-robin arbiter sharing one memory port between CPU data, CPU fetch and UART DMA.
// Defining MMU_ARB_PERF_EN adds the per-requester grant_cnt counters.
module mmu_mem_arbiter #(
    parameter int          AW        = 16,
    parameter int          DW        = 32,
    parameter int unsigned MEM_WORDS = 16384,
    parameter int          MEM_LAT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      req_valid,
    input  logic [2:0]      req_we,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*DW-1:0] req_wdata,
    output logic [2:0]      req_ready,
    output logic [2:0]      resp_valid,
    output logic            resp_err,
    output logic [DW-1:0]   resp_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
`ifdef MMU_ARB_PERF_EN
   ,output logic [47:0]     grant_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CW = $clog2(MEM_LAT + 1);
    state_t state;
    logic [1:0] last, w, p0, p1, p2;
    logic [CW-1:0] cnt;
    logic err, accept, in_range;
    logic [AW-1:0] sel_addr;
    function automatic logic [1:0] nx(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction
    // last doubles as the index of the requester currently being served
    always_comb begin
        p0 = nx(last);
        p1 = nx(p0);
        p2 = nx(p1);
        w = req_valid[p0] ? p0 : req_valid[p1] ? p1 : p2;
        accept = state == IDLE && !rst && |req_valid;
        req_ready = accept ? 3'b001 << w : 3'b000;
        sel_addr = req_addr[w*AW +: AW];
        in_range = 32'(sel_addr) < MEM_WORDS;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last <= 2'd2;
            cnt <= '0;
            err <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            resp_valid <= '0;
            resp_err <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    last <= w;
                    mem_addr <= sel_addr;
                    mem_we <= req_we[w];
                    mem_wdata <= req_wdata[w*DW +: DW];
                    mem_en <= in_range;
                    err <= !in_range;
                    state <= ISSUE;
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt <= CW'(1);
                    if (!err && !mem_we) state <= WAIT;
                    else begin
                        resp_valid <= 3'b001 << last;
                        resp_err <= err;
                        state <= RESP;
                    end
                end
                WAIT: if (cnt == CW'(MEM_LAT)) begin
                    resp_rdata <= mem_rdata;
                    resp_valid <= 3'b001 << last;
                    state <= RESP;
                end else cnt <= cnt + 1'b1;
                RESP: begin
                    resp_valid <= '0;
                    resp_err <= 1'b0;
                    resp_rdata <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
`ifdef MMU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) grant_cnt[i*16 +: 16] <= '0;
            else if (req_ready[i] && req_valid[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// tb_mmu_mem_arbiter: table-driven transactions with a response scoreboard plus reset and round-robin sequences.
module tb_mmu_mem_arbiter;
    localparam int AW = 16, DW = 32, LAT = 2;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic [2:0] req_valid = '0, req_we = '0;
    logic [3*AW-1:0] req_addr = '0;
    logic [3*DW-1:0] req_wdata = '0;
    logic [2:0] req_ready, resp_valid;
    logic resp_err, mem_en, mem_we;
    logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
`ifdef MMU_ARB_PERF_EN
    logic [47:0] grant_cnt;
`endif
    mmu_mem_arbiter #(.AW(AW), .DW(DW), .MEM_WORDS(16384), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MMU_ARB_PERF_EN
       ,.grant_cnt(grant_cnt)
`endif
    );

    logic [31:0] mem [0:16383];
    logic [31:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[13:0]] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[13:0]] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    typedef struct {logic [2:0] valid; logic err; logic [31:0] rdata;} exp_t;
    typedef struct {int req; logic we; logic [15:0] addr; logic [31:0] wdata; logic err; logic [31:0] rdata; int lat;} vec_t;
    exp_t q[$];
    exp_t e_mon;
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid != 3'b000) begin
            if (q.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
            else begin
                e_mon = q.pop_front();
                chk("resp_valid", 64'(resp_valid), 64'(e_mon.valid));
                chk("resp_err", 64'(resp_err), 64'(e_mon.err));
                chk("resp_rdata", 64'(resp_rdata), 64'(e_mon.rdata));
            end
        end
        if (mem_en) chk("mem_en_range", 64'(mem_addr < 16'd16384), 64'd1);
    end

    task automatic drive(input int i, input logic we, input logic [15:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input int i, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.valid = 3'b001 << i;
        e.err = err;
        e.rdata = rdata;
        q.push_back(e);
    endtask

    task automatic run_one(input vec_t v);
        int n = 0;
        int lat = 0;
        @(posedge clk); #1;
        drive(v.req, v.we, v.addr, v.wdata);
        @(negedge clk);
        while (req_ready == 3'b000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 64'(req_ready), 64'(3'b001 << v.req));
        push(v.req, v.err, v.rdata);
        @(posedge clk); #1;
        req_valid = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("mem_en", 64'(mem_en), 64'(!v.err));
                if (!v.err) begin
                    chk("mem_we", 64'(mem_we), 64'(v.we));
                    chk("mem_addr", 64'(mem_addr), 64'(v.addr));
                    if (v.we) chk("mem_wdata", 64'(mem_wdata), 64'(v.wdata));
                end
            end
        end while (resp_valid == 3'b000 && lat < 20);
        chk("latency", 64'(lat), 64'(v.lat));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    vec_t vecs[10];
    int order[6] = '{0, 1, 2, 0, 1, 2};
    logic [31:0] rr_data[3] = '{32'hCAFEF00D, 32'h12345678, 32'hA5A5A5A5};

    initial begin
        vecs[0] = '{0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 2};
        vecs[1] = '{1, 1'b0, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 2 + LAT};
        vecs[2] = '{2, 1'b1, 16'h3FFF, 32'h12345678, 1'b0, 32'h0, 2};
        vecs[3] = '{0, 1'b0, 16'h3FFF, 32'h0, 1'b0, 32'h12345678, 2 + LAT};
        vecs[4] = '{2, 1'b0, 16'h4000, 32'h0, 1'b1, 32'h0, 2};
        vecs[5] = '{1, 1'b1, 16'hFFFF, 32'h11111111, 1'b1, 32'h0, 2};
        vecs[6] = '{0, 1'b1, 16'h0000, 32'hA5A5A5A5, 1'b0, 32'h0, 2};
        vecs[7] = '{2, 1'b0, 16'h0000, 32'h0, 1'b0, 32'hA5A5A5A5, 2 + LAT};
        vecs[8] = '{1, 1'b1, 16'h0010, 32'hCAFEF00D, 1'b0, 32'h0, 2};
        vecs[9] = '{1, 1'b0, 16'h0010, 32'h0, 1'b0, 32'hCAFEF00D, 2 + LAT};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 64'd0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;
        foreach (vecs[i]) run_one(vecs[i]);
        drain();

        pulse_reset();
        drive(0, 1'b0, 16'h0010, 32'h0);
        drive(1, 1'b0, 16'h3FFF, 32'h0);
        drive(2, 1'b0, 16'h0000, 32'h0);
        begin
            int g = 0;
            int n = 0;
            while (g < 6 && n < 100) begin
                @(negedge clk);
                n++;
                if (req_ready != 3'b000) begin
                    chk("rr_grant", 64'(req_ready), 64'(3'b001 << order[g]));
                    push(order[g], 1'b0, rr_data[order[g]]);
                    g++;
                end
            end
            chk("rr_count", 64'(g), 64'd6);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        begin
            int n = 0;
            @(posedge clk); #1;
            drive(1, 1'b0, 16'h3FFF, 32'h0);
            @(negedge clk);
            while (req_ready == 3'b000 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("mid_grant", 64'(req_ready), 64'b010);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 16'h0010, 32'h0);
        drive(2, 1'b0, 16'h0000, 32'h0);
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'b001);
        chk("post_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        chk("post_rst_resp", {resp_valid, resp_err, resp_rdata}, 64'd0);
        push(0, 1'b0, 32'hCAFEF00D);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(negedge clk);
        drain();

`ifdef MMU_ARB_PERF_EN
        pulse_reset();
        for (int i = 0; i < 5; i++) run_one('{1, 1'b1, 16'(32 + i), 32'(i), 1'b0, 32'h0, 2});
        @(negedge clk);
        chk("grant_cnt", 64'(grant_cnt), {16'd0, 16'd0, 16'd5, 16'd0});
`endif
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mmu_mem_arbiter.md
# mmu_mem_arbiter

Single-port memory arbiter for the CPU/MMU integration. It shares one synchronous memory port between three requesters: CPU data access, CPU instruction fetch and UART transmit DMA. Requesters are served with round-robin fairness, one transaction in flight at a time. Out-of-range addresses are rejected with an error response instead of a memory access. The block sits between the CPU/UART request logic and the MMU-backed memory inside `cpu_mmu_integration`.

## Interface
- `AW`, 16: address width (word address).
- `DW`, 32: data width.
- `MEM_WORDS`, 16384: valid address range is 0..MEM_WORDS-1.
- `MEM_LAT`, 2: memory read latency in cycles, ≥1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  3  per-requester request valid. Bit 0 = CPU data, 1 = CPU fetch, 2 = UART DMA.
- `req_we`  in  3  per-requester write enable.
- `req_addr`  in  3*AW  packed addresses; requester i occupies [i*AW +: AW].
- `req_wdata`  in  3*DW  packed write data.
- `req_ready`  out  3  one-hot accept; handshake = valid & ready.
- `resp_valid`  out  3  one-hot, one-cycle response strobe.
- `resp_err`  out  1  qualifies `resp_valid`: address out of range.
- `resp_rdata`  out  DW  read data, qualified by `resp_valid`.
- `mem_en`  out  1  one-cycle memory access strobe.
- `mem_we`  out  1  write select for `mem_en`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid MEM_LAT cycles after `mem_en`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` bit is set, pick a winner w by round-robin starting from `last+1` (mod 3).
  - Assert `req_ready[w]` combinationally in this cycle only.
  - Capture w, addr, we, wdata; set `last`=w; go to ISSUE.
  - `req_ready` is 0 in every other state.
- **ISSUE**
  - In range, write: `mem_en`=1, `mem_we`=1 → RESP.
  - In range, read: `mem_en`=1, `mem_we`=0 → WAIT.
  - Out of range (addr ≥ MEM_WORDS): `mem_en` stays 0, set error flag → RESP.
- **WAIT**
  - Count MEM_LAT cycles after the `mem_en` cycle.
  - On the cycle `mem_rdata` is valid, register it → RESP.
- **RESP**
  - `resp_valid[w]`=1 for one cycle.
  - `resp_rdata` = captured read data on reads; 0 on writes and on errors.
  - `resp_err` = error flag.
  - Return to IDLE.
- Round-robin pointer `last` resets to 2, so requester 0 wins the first contested grant.
- `mem_addr`, `mem_we`, `mem_wdata` are registered from the captured request and hold their value outside ISSUE. Only `mem_en` qualifies them.
- A requester that deasserts `req_valid` before its grant is simply not served; no state changes for it.
- A requester whose request is served and is still valid in the next IDLE is ordered behind the other requesters by the pointer.
- Requests are never reordered or merged. The `resp_valid` bit always matches the granted requester.

## Timing
- Let accept cycle = T.
  - `mem_en` is high at T+1.
  - Write response: T+2.
  - Read response: T+2+MEM_LAT.
  - Error response: T+2.
- Earliest next accept:
  - After a write or error: T+3.
  - After a read: T+3+MEM_LAT.
- Reset values: state IDLE, `last`=2.
- All outputs are 0 during and after reset: `req_ready`, `resp_valid`, `resp_err`, `resp_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`.
- Reset mid-transaction:
  - Abandons the transaction; no `resp_valid` is issued for it.
  - Late `mem_rdata` is ignored.
  - The first accept is possible in the first cycle after `rst` deasserts.
- Simultaneous requests:
  - All three valid in IDLE with `last`=0 → grant order 1, 2, 0.
  - Only one valid → that requester is granted regardless of `last`.

## Configuration
- `MMU_ARB_PERF_EN`
  - Defined: adds output port `grant_cnt` (out, 48): three 16-bit counters at [i*16 +: 16], each counting accepted handshakes of requester i.
  - Counters saturate at 16'hFFFF and reset to 0 on `rst`.
  - Not defined: port and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then requester 0 writes addr 0x0010, data 0xDEADBEEF:
  - `req_ready[0]` at T; `mem_en`/`mem_we`=1 with addr 0x0010 at T+1; `resp_valid`=3'b001, `resp_err`=0 at T+2.
- Requester 1 reads 0x0010 with MEM_LAT=2 and the memory model returning the stored word:
  - `resp_valid`=3'b010, `resp_rdata`=0xDEADBEEF at T+4.
- All three requesters held valid with reads → grants in order 0, 1, 2, 0, 1, 2; each response strobe matches its grant.
- Requester 2 reads addr MEM_WORDS (16384):
  - No `mem_en`; `resp_valid`=3'b100, `resp_err`=1, `resp_rdata`=0 at T+2.
- Assert `rst` for one cycle during WAIT of a read:
  - No `resp_valid` for that read; all outputs 0; the next request is accepted right after reset with requester 0 first.
- With `MMU_ARB_PERF_EN`, issue 5 transactions from requester 1 → `grant_cnt[31:16]`=5, other counters 0.
